// File: rtl/mips_cache_controller.sv
// Memory-side cache controller: single-word refills and byte-enabled write-throughs over an Avalon-style bus.
// Optional waitrequest timeout with sticky mem_error is enabled by defining CACHE_CTRL_TIMEOUT_EN.
module mips_cache_controller #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TIMEOUT_BITS   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_addr,
    input  logic        stall,
    input  logic        write_en,
    input  logic [31:0] writedata,
    input  logic [3:0]  byte_en,
    output logic [31:0] data_in,
    output logic        data_valid,
    output logic        wr_stall,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
    input  logic [31:0] mem_readdata,
    input  logic        mem_waitrequest,
    output logic        mem_error
);
    typedef enum logic [1:0] {IDLE, RD_REQ, RD_DONE, WR_REQ} state_t;

    state_t      state, state_d;
    logic [31:0] data_in_d, mem_address_d, mem_writedata_d;
    logic [3:0]  mem_byteenable_d;
    logic        data_valid_d, wr_stall_d, mem_read_d, mem_write_d, mem_error_d;
    logic        timeout;
    logic        addr_lo_unused;

    // The bus is word-addressed; the byte offset of a miss is irrelevant here.
    assign addr_lo_unused = ^data_addr[1:0];

`ifdef CACHE_CTRL_TIMEOUT_EN
    logic [TIMEOUT_BITS-1:0] wait_cnt;

    // Cleared while idle so every transaction starts counting from zero.
    always_ff @(posedge clk) begin
        if (!rst)
            wait_cnt <= '0;
        else if (state == IDLE)
            wait_cnt <= '0;
        else if (mem_waitrequest)
            wait_cnt <= wait_cnt + 1'b1;
    end

    assign timeout = mem_waitrequest && (wait_cnt == TIMEOUT_BITS'(TIMEOUT_CYCLES - 1));
`else
    localparam int cfg_unused = TIMEOUT_CYCLES + TIMEOUT_BITS;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d          = state;
        data_in_d        = data_in;
        data_valid_d     = 1'b0;
        wr_stall_d       = wr_stall;
        mem_read_d       = mem_read;
        mem_write_d      = mem_write;
        mem_address_d    = mem_address;
        mem_writedata_d  = mem_writedata;
        mem_byteenable_d = mem_byteenable;
        mem_error_d      = mem_error || timeout;
        case (state)
            IDLE: begin
                // Refills win over writes so the stalled pipeline resumes first.
                if (stall) begin
                    mem_address_d    = {data_addr[31:2], 2'b00};
                    mem_byteenable_d = 4'hF;
                    mem_read_d       = 1'b1;
                    state_d          = RD_REQ;
                end else if (write_en && (byte_en != 4'h0)) begin
                    mem_address_d    = {data_addr[31:2], 2'b00};
                    mem_writedata_d  = writedata;
                    mem_byteenable_d = byte_en;
                    mem_write_d      = 1'b1;
                    wr_stall_d       = 1'b1;
                    state_d          = WR_REQ;
                end
            end
            RD_REQ: begin
                if (timeout) begin
                    data_in_d    = 32'hDEADBEEF;
                    mem_read_d   = 1'b0;
                    data_valid_d = 1'b1;
                    state_d      = RD_DONE;
                end else if (!mem_waitrequest) begin
                    data_in_d    = mem_readdata;
                    mem_read_d   = 1'b0;
                    data_valid_d = 1'b1;
                    state_d      = RD_DONE;
                end
            end
            RD_DONE: state_d = IDLE;
            WR_REQ: begin
                if (timeout || !mem_waitrequest) begin
                    mem_write_d = 1'b0;
                    wr_stall_d  = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            data_in        <= '0;
            data_valid     <= 1'b0;
            wr_stall       <= 1'b0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_writedata  <= '0;
            mem_byteenable <= '0;
            mem_error      <= 1'b0;
        end else begin
            state          <= state_d;
            data_in        <= data_in_d;
            data_valid     <= data_valid_d;
            wr_stall       <= wr_stall_d;
            mem_read       <= mem_read_d;
            mem_write      <= mem_write_d;
            mem_address    <= mem_address_d;
            mem_writedata  <= mem_writedata_d;
            mem_byteenable <= mem_byteenable_d;
            mem_error      <= mem_error_d;
        end
    end
endmodule

// File: tb/tb_mips_cache_controller.sv
// Bench for mips_cache_controller: randomized refills/writes against a word-array memory model.
// Define CACHE_CTRL_TIMEOUT_EN to build the DUT with a 4-cycle timeout and run the timeout scenario.
module tb_mips_cache_controller;
`ifdef CACHE_CTRL_TIMEOUT_EN
    localparam int TO_CYC  = 4;
    localparam int TO_BITS = 3;
`else
    localparam int TO_CYC  = 256;
    localparam int TO_BITS = 8;
`endif
    // Longest waitrequest run that must not trip a timeout.
    localparam int MAXW = (TO_CYC > 6) ? 6 : TO_CYC - 1;

    logic        clk = 1'b0;
    logic        rst, stall, write_en, data_valid, wr_stall;
    logic        mem_read, mem_write, mem_waitrequest, mem_error, mem_init;
    logic [31:0] data_addr, writedata, data_in, mem_address, mem_writedata, mem_readdata;
    logic [3:0]  byte_en, mem_byteenable;

    logic [31:0] dev_mem [0:255];
    logic [31:0] ref_mem [0:255];
    int checks = 0;
    int errors = 0;

    mips_cache_controller #(.TIMEOUT_CYCLES(TO_CYC), .TIMEOUT_BITS(TO_BITS)) dut (
        .clk(clk), .rst(rst), .data_addr(data_addr), .stall(stall),
        .write_en(write_en), .writedata(writedata), .byte_en(byte_en),
        .data_in(data_in), .data_valid(data_valid), .wr_stall(wr_stall),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
        .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest),
        .mem_error(mem_error)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_seed(input int i);
        if (i == 1) return 32'hCAFEF00D;
        return 32'h1234_5678 ^ (32'(i) * 32'h9E37_79B9);
    endfunction

    // Memory device: junk on readdata while busy, byte-merged writes on acceptance.
    always_comb mem_readdata = mem_waitrequest ? 32'hBAD0_BAD0 : dev_mem[mem_address[9:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) dev_mem[i] <= mem_seed(i);
        end else if (mem_write && !mem_waitrequest) begin
            for (int b = 0; b < 4; b++)
                if (mem_byteenable[b]) dev_mem[mem_address[9:2]][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
    end

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({data_in, data_valid, wr_stall, mem_read, mem_write, mem_address,
             mem_writedata, mem_byteenable, mem_error} !== '0) begin
            errors++;
            $display("FAIL reset_values: data_in=%h dv=%b wrs=%b rd=%b wr=%b addr=%h wd=%h be=%b err=%b, all required 0",
                     data_in, data_valid, wr_stall, mem_read, mem_write, mem_address,
                     mem_writedata, mem_byteenable, mem_error);
        end
        mem_init = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_read, mem_write, data_valid, wr_stall} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_after_reset: rd/wr/dv/wrs=%b required 0000",
                     {mem_read, mem_write, data_valid, wr_stall});
        end
    endtask

    task automatic test_refill(input int n_rand);
        logic [31:0] a, exp_addr, dv_data;
        int n, cyc, rd_cyc, dv_cyc;
        bit bus_ok;
        for (int t = 0; t < n_rand + 2; t++) begin
            if (t == 0) begin a = 32'h0000_1006; n = 0; end
            else if (t == 1) begin a = 32'h0000_0ABD; n = (MAXW >= 5) ? 5 : MAXW; end
            else begin a = $urandom; n = $urandom_range(0, MAXW); end
            exp_addr = {a[31:2], 2'b00};
            @(posedge clk); #1;
            stall = 1'b1; data_addr = a;
            cyc = 0; rd_cyc = 0; dv_cyc = 0; bus_ok = 1'b1; dv_data = '0;
            while (dv_cyc == 0 && cyc < n + 20) begin
                @(posedge clk); #1;
                cyc++;
                data_addr = $urandom;
                writedata = $urandom;
                mem_waitrequest = (cyc <= n);
                @(negedge clk);
                if (mem_read === 1'b1) begin
                    rd_cyc++;
                    if (mem_address !== exp_addr || mem_byteenable !== 4'hF || mem_write !== 1'b0) bus_ok = 1'b0;
                end
                if (data_valid === 1'b1) begin dv_cyc = cyc; dv_data = data_in; end
            end
            @(posedge clk); #1;
            stall = 1'b0; mem_waitrequest = 1'b0;
            @(negedge clk);
            checks++;
            if (dv_cyc != n + 2) begin
                errors++;
                $display("FAIL refill_latency[%0d]: data_valid at cycle %0d required %0d", t, dv_cyc, n + 2);
            end
            checks++;
            if (dv_data !== ref_mem[a[9:2]]) begin
                errors++;
                $display("FAIL refill_data[%0d]: data_in=%h required %h", t, dv_data, ref_mem[a[9:2]]);
            end
            checks++;
            if (rd_cyc != n + 1) begin
                errors++;
                $display("FAIL refill_read_cycles[%0d]: mem_read high %0d cycles required %0d", t, rd_cyc, n + 1);
            end
            checks++;
            if (!bus_ok) begin
                errors++;
                $display("FAIL refill_bus_stable[%0d]: address/byteenable not held at %h/1111", t, exp_addr);
            end
            checks++;
            if (data_valid !== 1'b0) begin
                errors++;
                $display("FAIL refill_single_pulse[%0d]: data_valid=%b required 0", t, data_valid);
            end
        end
    endtask

    task automatic test_write(input int n_rand);
        logic [31:0] a, d, exp_addr;
        logic [3:0] be;
        int n, cyc, wr_cyc;
        bit fields_ok, stall_ok, done;
        for (int t = 0; t < n_rand + 1; t++) begin
            if (t == 0) begin a = 32'h20; d = 32'h1122_3344; be = 4'b0101; n = 2; end
            else begin
                a = $urandom; d = $urandom; be = 4'($urandom_range(1, 15)); n = $urandom_range(0, MAXW);
            end
            exp_addr = {a[31:2], 2'b00};
            for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
            @(posedge clk); #1;
            data_addr = a; writedata = d; byte_en = be; write_en = 1'b1;
            cyc = 0; wr_cyc = 0; fields_ok = 1'b1; stall_ok = 1'b1; done = 1'b0;
            while (!done && cyc < n + 20) begin
                @(posedge clk); #1;
                cyc++;
                write_en = 1'b0;
                data_addr = $urandom; writedata = $urandom; byte_en = 4'($urandom);
                mem_waitrequest = (cyc <= n);
                @(negedge clk);
                if (wr_stall !== mem_write) stall_ok = 1'b0;
                if (mem_write === 1'b1) begin
                    wr_cyc++;
                    if (mem_address !== exp_addr || mem_writedata !== d ||
                        mem_byteenable !== be || mem_read !== 1'b0) fields_ok = 1'b0;
                end else if (wr_cyc > 0) done = 1'b1;
            end
            mem_waitrequest = 1'b0;
            checks++;
            if (wr_cyc != n + 1) begin
                errors++;
                $display("FAIL write_cycles[%0d]: mem_write high %0d cycles required %0d", t, wr_cyc, n + 1);
            end
            checks++;
            if (!fields_ok) begin
                errors++;
                $display("FAIL write_fields[%0d]: addr/data/be not held at %h/%h/%b", t, exp_addr, d, be);
            end
            checks++;
            if (!stall_ok) begin
                errors++;
                $display("FAIL write_wr_stall[%0d]: wr_stall did not track mem_write", t);
            end
            checks++;
            if (dev_mem[a[9:2]] !== ref_mem[a[9:2]]) begin
                errors++;
                $display("FAIL write_memory[%0d]: word=%h required %h", t, dev_mem[a[9:2]], ref_mem[a[9:2]]);
            end
        end
    endtask

    task automatic test_byte_en_zero();
        bit quiet = 1'b1;
        @(posedge clk); #1;
        data_addr = $urandom; writedata = $urandom; byte_en = 4'h0; write_en = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (mem_write !== 1'b0 || wr_stall !== 1'b0 || mem_read !== 1'b0) quiet = 1'b0;
        end
        @(posedge clk); #1;
        write_en = 1'b0;
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL byte_en_zero: write with byte_en=0 started a bus cycle (wr=%b wrs=%b)", mem_write, wr_stall);
        end
    endtask

    task automatic test_priority();
        logic [31:0] a, d, old_word, dv_data;
        logic [3:0] be;
        int rd_c, dv_c, wr_c, overlap;
        a = $urandom; d = $urandom; be = 4'($urandom_range(1, 15));
        old_word = ref_mem[a[9:2]];
        @(posedge clk); #1;
        stall = 1'b1; write_en = 1'b1; data_addr = a; writedata = d; byte_en = be; mem_waitrequest = 1'b0;
        rd_c = 0; dv_c = 0; wr_c = 0; overlap = 0; dv_data = '0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (dv_c != 0) stall = 1'b0;
            if (wr_c != 0) write_en = 1'b0;
            @(negedge clk);
            if (mem_read === 1'b1 && mem_write === 1'b1) overlap++;
            if (mem_read === 1'b1 && rd_c == 0) rd_c = c;
            if (data_valid === 1'b1 && dv_c == 0) begin dv_c = c; dv_data = data_in; end
            if (mem_write === 1'b1 && wr_c == 0) wr_c = c;
        end
        for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
        checks++;
        if (rd_c != 1 || dv_c != 2 || wr_c != 4) begin
            errors++;
            $display("FAIL priority_order: read@%0d valid@%0d write@%0d required 1/2/4", rd_c, dv_c, wr_c);
        end
        checks++;
        if (dv_data !== old_word) begin
            errors++;
            $display("FAIL priority_read_data: data_in=%h required %h", dv_data, old_word);
        end
        checks++;
        if (overlap != 0) begin
            errors++;
            $display("FAIL priority_overlap: mem_read and mem_write both high %0d cycles required 0", overlap);
        end
        checks++;
        if (dev_mem[a[9:2]] !== ref_mem[a[9:2]]) begin
            errors++;
            $display("FAIL priority_write_memory: word=%h required %h", dev_mem[a[9:2]], ref_mem[a[9:2]]);
        end
    endtask

    task automatic test_reset_abort();
        bit quiet = 1'b1;
        @(posedge clk); #1;
        stall = 1'b1; data_addr = $urandom; mem_waitrequest = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_flight: mem_read=%b required 1", mem_read);
        end
        @(posedge clk); #1;
        rst = 1'b0; mem_waitrequest = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({data_in, data_valid, wr_stall, mem_read, mem_write, mem_address,
             mem_writedata, mem_byteenable, mem_error} !== '0) begin
            errors++;
            $display("FAIL abort_reset_values: data_in=%h dv=%b rd=%b addr=%h be=%b, all required 0",
                     data_in, data_valid, mem_read, mem_address, mem_byteenable);
        end
        @(posedge clk); #1;
        stall = 1'b0; rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (data_valid !== 1'b0 || mem_read !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL abort_no_valid: aborted refill produced data_valid or mem_read after reset");
        end
    endtask

`ifdef CACHE_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        logic [31:0] a, dv_data, old_word;
        int rd_c, dv_c, err_c, wr_c;
        a = $urandom;
        old_word = ref_mem[a[9:2]];
        @(posedge clk); #1;
        stall = 1'b1; data_addr = a; mem_waitrequest = 1'b1;
        rd_c = 0; dv_c = 0; err_c = 0; dv_data = '0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (dv_c != 0) stall = 1'b0;
            @(negedge clk);
            if (mem_read === 1'b1) rd_c++;
            if (data_valid === 1'b1 && dv_c == 0) begin dv_c = c; dv_data = data_in; end
            if (mem_error === 1'b1 && err_c == 0) err_c = c;
        end
        checks++;
        if (rd_c != 4 || dv_c != 5 || err_c != 5) begin
            errors++;
            $display("FAIL timeout_read: read cycles %0d valid@%0d error@%0d required 4/5/5", rd_c, dv_c, err_c);
        end
        checks++;
        if (dv_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL timeout_read_data: data_in=%h required deadbeef", dv_data);
        end
        @(posedge clk); #1;
        data_addr = a; writedata = ~old_word; byte_en = 4'hF; write_en = 1'b1;
        wr_c = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            write_en = 1'b0;
            @(negedge clk);
            if (mem_write === 1'b1) wr_c++;
        end
        checks++;
        if (wr_c != 4 || wr_stall !== 1'b0 || dev_mem[a[9:2]] !== old_word) begin
            errors++;
            $display("FAIL timeout_write: write cycles %0d wr_stall=%b word=%h required 4/0/%h",
                     wr_c, wr_stall, dev_mem[a[9:2]], old_word);
        end
        checks++;
        if (mem_error !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: mem_error=%b required 1", mem_error);
        end
        mem_waitrequest = 1'b0;
        test_reset();
        checks++;
        if (mem_error !== 1'b0) begin
            errors++;
            $display("FAIL timeout_cleared: mem_error=%b required 0 after reset", mem_error);
        end
    endtask
`else
    task automatic test_no_timeout();
        logic [31:0] a;
        int dv_c;
        bit held = 1'b1;
        logic [31:0] dv_data = '0;
        a = $urandom;
        @(posedge clk); #1;
        stall = 1'b1; data_addr = a; mem_waitrequest = 1'b1;
        dv_c = 0;
        for (int c = 1; c <= 26; c++) begin
            @(posedge clk); #1;
            if (c == 21) mem_waitrequest = 1'b0;
            if (dv_c != 0) stall = 1'b0;
            @(negedge clk);
            if (c <= 21 && (mem_read !== 1'b1 || data_valid !== 1'b0)) held = 1'b0;
            if (mem_error !== 1'b0) held = 1'b0;
            if (data_valid === 1'b1 && dv_c == 0) begin dv_c = c; dv_data = data_in; end
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL no_timeout_hold: request dropped or mem_error raised during long waitrequest");
        end
        checks++;
        if (dv_c != 22 || dv_data !== ref_mem[a[9:2]]) begin
            errors++;
            $display("FAIL no_timeout_refill: valid@%0d data=%h required 22/%h", dv_c, dv_data, ref_mem[a[9:2]]);
        end
    endtask
`endif

    initial begin
        rst = 1'b0; stall = 1'b0; write_en = 1'b0; data_addr = '0; writedata = '0;
        byte_en = '0; mem_waitrequest = 1'b0; mem_init = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem_seed(i);
        test_reset();
        test_refill(20);
        test_write(20);
        test_byte_en_zero();
        test_priority();
        test_reset_abort();
        test_refill(5);
`ifdef CACHE_CTRL_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
